// File: rtl/pc_redirect_sequencer.sv
// Fetch PC sequencer: advances the fetch address by 4, accepts Execute redirects and drives the IF/ID flush window.
// Optional macro MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_PC and pulses misalign_err.
module pc_redirect_sequencer #(
   parameter int unsigned     PC_W         = 8,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter int unsigned     FLUSH_CYCLES = 2,
   parameter logic [PC_W-1:0] TRAP_PC      = PC_W'(252)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            redir_valid,
   input  logic [PC_W-1:0] redir_target,
   output logic            redir_ready,
   output logic [PC_W-1:0] pc,
   output logic            fetch_valid,
   output logic            flush,
   output logic [7:0]      redir_count,
   output logic            misalign_err
);

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [PC_W-1:0] pc_d;
   logic            fetch_valid_d;
   logic            flush_d;
   logic [7:0]      redir_count_d;
   logic            misalign_err_d;
   logic [PC_W-1:0] load_pc;
   logic            misaligned;

`ifdef MISALIGN_TRAP_EN
   assign misaligned = |redir_target[1:0];
   assign load_pc    = misaligned ? TRAP_PC : redir_target;
`else
   logic unused_lsbs;
   assign misaligned  = 1'b0;
   assign load_pc     = {redir_target[PC_W-1:2], 2'b00};
   assign unused_lsbs = ^{redir_target[1:0], TRAP_PC};
`endif

   assign redir_ready = (state_q == S_RUN);

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
      state_d        = state_q;
      cnt_d          = cnt_q;
      pc_d           = pc;
      fetch_valid_d  = fetch_valid;
      flush_d        = 1'b0;
      redir_count_d  = redir_count;
      misalign_err_d = 1'b0;

      unique case (state_q)
         S_RUN: begin
            if (redir_valid) begin
               pc_d           = load_pc;
               flush_d        = 1'b1;
               fetch_valid_d  = 1'b0;
               cnt_d          = FLUSH_LOAD;
               redir_count_d  = redir_count + 8'd1;
               misalign_err_d = misaligned;
               state_d        = S_FLUSH;
            end else if (!fetch_valid) begin
               // First edge out of reset: the reset PC itself is the first fetch.
               fetch_valid_d = 1'b1;
            end else if (!stall) begin
               pc_d = pc + PC_W'(4);
            end
         end
         S_FLUSH: begin
            if (cnt_q == 4'd0) begin
               fetch_valid_d = 1'b1;
               state_d       = S_RUN;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               flush_d = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         state_q      <= S_RUN;
         cnt_q        <= 4'd0;
         pc           <= RESET_PC;
         fetch_valid  <= 1'b0;
         flush        <= 1'b0;
         redir_count  <= 8'd0;
         misalign_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pc           <= pc_d;
         fetch_valid  <= fetch_valid_d;
         flush        <= flush_d;
         redir_count  <= redir_count_d;
         misalign_err <= misalign_err_d;
      end
   end

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Scoreboard bench for pc_redirect_sequencer: a cycle model pushes expected outputs per driven edge, compared after the edge.
module tb_pc_redirect_sequencer;

   localparam int FLUSH_N = 2;

   logic       clk;
   logic       rst_n;
   logic       stall;
   logic       redir_valid;
   logic [7:0] redir_target;
   logic       redir_ready;
   logic [7:0] pc;
   logic       fetch_valid;
   logic       flush;
   logic [7:0] redir_count;
   logic       misalign_err;

   pc_redirect_sequencer #(
      .PC_W(8), .RESET_PC(8'd0), .FLUSH_CYCLES(FLUSH_N), .TRAP_PC(8'd252)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redir_valid(redir_valid),
      .redir_target(redir_target), .redir_ready(redir_ready), .pc(pc),
      .fetch_valid(fetch_valid), .flush(flush), .redir_count(redir_count),
      .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pc;
      logic       fv;
      logic       flush;
      logic       ready;
      logic [7:0] cnt;
      logic       merr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   step_no  = 0;

   // Reference model: m_left counts flush cycles still to be shown.
   logic [7:0] m_pc;
   logic       m_fv, m_flush, m_merr;
   logic [7:0] m_cnt;
   int         m_left;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s (step %0d): got %0h, expected %0h", tag, step_no, got, want);
      end
   endtask

   task automatic model_edge(input logic r, input logic st, input logic v, input logic [7:0] t);
      if (!r) begin
         m_pc = 8'd0; m_fv = 1'b0; m_flush = 1'b0; m_left = 0; m_cnt = 8'd0; m_merr = 1'b0;
      end else begin
         m_merr = 1'b0;
         if (m_left != 0) begin
            m_left--;
            m_flush = (m_left != 0);
            m_fv    = (m_left == 0);
         end else if (v) begin
            m_left  = FLUSH_N;
            m_flush = 1'b1;
            m_fv    = 1'b0;
            m_cnt   = m_cnt + 8'd1;
`ifdef MISALIGN_TRAP_EN
            if (t[1:0] != 2'b00) begin
               m_pc = 8'd252; m_merr = 1'b1;
            end else begin
               m_pc = t;
            end
`else
            m_pc = t & 8'hFC;
`endif
         end else if (!m_fv) begin
            m_fv = 1'b1;
         end else if (!st) begin
            m_pc = m_pc + 8'd4;
         end
      end
   endtask

   task automatic compare_out();
      exp_t e;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("pc", 32'(pc), 32'(e.pc));
         check("fetch_valid", 32'(fetch_valid), 32'(e.fv));
         check("flush", 32'(flush), 32'(e.flush));
         check("redir_ready", 32'(redir_ready), 32'(e.ready));
         check("redir_count", 32'(redir_count), 32'(e.cnt));
         check("misalign_err", 32'(misalign_err), 32'(e.merr));
      end
   endtask

   task automatic step(input logic r, input logic st, input logic v, input logic [7:0] t);
      exp_t e;
      rst_n = r; stall = st; redir_valid = v; redir_target = t;
      model_edge(r, st, v, t);
      e.pc = m_pc; e.fv = m_fv; e.flush = m_flush; e.ready = (m_left == 0);
      e.cnt = m_cnt; e.merr = m_merr;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      step_no++;
      compare_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_target = 8'd0;
      m_pc = 8'd0; m_fv = 1'b0; m_flush = 1'b0; m_left = 0; m_cnt = 8'd0; m_merr = 1'b0;
      @(negedge clk);

      // Reset, then free run: pc 0,0,4,8,12
      step(1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b0, 8'd0);
      idle(4);

      // Stall alone holds pc, then advance to 16
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'd0);
      idle(1);

      // Redirect to 100 at pc=16, flush window, then 100, 104
      step(1'b1, 1'b0, 1'b1, 8'd100);
      idle(4);

      // Redirect together with stall; stall and redir_valid held high through flush are ignored
      step(1'b1, 1'b1, 1'b1, 8'd40);
      step(1'b1, 1'b1, 1'b1, 8'd80);
      step(1'b1, 1'b1, 1'b0, 8'd80);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'd0);

      // Wrap: 248, 252, 0, 4
      step(1'b1, 1'b0, 1'b1, 8'd248);
      idle(5);

      // Misaligned target 0x65
      step(1'b1, 1'b0, 1'b1, 8'h65);
      idle(4);

      // Adjacent redirects: valid held, re-accepted in first RUN cycle after flush
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 8'd200);
      idle(2);

      // Reset during the second flush cycle
      step(1'b1, 1'b0, 1'b1, 8'd60);
      step(1'b1, 1'b0, 1'b0, 8'd0);
      step(1'b0, 1'b0, 1'b0, 8'd0);
      idle(3);

      if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_redirect_sequencer.md
Name: pc_redirect_sequencer

Overview:
Fetch-side PC sequencer at the receiving end of the Execute-stage branch-target path. It holds the 8-bit fetch PC and advances it by 4 each cycle. It accepts branch/jump redirects (valid/ready) carrying the target produced in Execute, and drives a flush window that kills wrong-path instructions in IF/ID. It sits between the hazard/stall logic, the instruction memory address input and the IF/ID pipeline register.

Parameters:
PC_W, 8, PC and target width (byte address)
RESET_PC, 8'd0, PC value loaded on reset
FLUSH_CYCLES, 2, cycles flush is held after an accepted redirect; legal range 1..15
TRAP_PC, 8'd252, PC loaded on misaligned target (MISALIGN_TRAP_EN only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  hazard-unit stall; holds PC when high
redir_valid  input  1  Execute presents a taken branch/jump
redir_target  input  PC_W  branch target from Execute
redir_ready  output  1  sequencer can accept a redirect this cycle
pc  output  PC_W  current fetch address to instruction memory
fetch_valid  output  1  pc is a valid, non-wrong-path fetch
flush  output  1  kill IF/ID contents
redir_count  output  8  number of accepted redirects, wraps at 255->0
misalign_err  output  1  one-cycle pulse on misaligned target

Behaviour:
- All outputs are registered. Reset is sampled only at the clk edge.
- Reset (rst_n=0 at an edge), including mid-flush:
  - state=RUN, pc=RESET_PC, fetch_valid=0, flush=0, flush counter=0, redir_count=0, misalign_err=0.
  - redir_ready is 1 in RUN (combinational from state); it is 1 after reset.
- First edge with rst_n=1: fetch_valid<=1 and pc holds RESET_PC, unless a redirect is accepted on that edge. No PC increment on that edge.
- States: RUN, FLUSH.
- RUN, priority highest first:
  - Accept (redir_valid & redir_ready), regardless of stall:
    - pc<=redir_target, flush<=1, fetch_valid<=0, counter<=FLUSH_CYCLES-1.
    - redir_count<=redir_count+1; state<=FLUSH.
  - Stall: pc, fetch_valid hold; flush=0.
  - Otherwise: pc<=pc+4, modulo 2^PC_W. 252+4 wraps to 0 with no flag. fetch_valid<=1.
- FLUSH:
  - redir_ready=0; redir_valid is ignored. Execute must hold it or drop it; the sequencer never queues it.
  - flush=1, fetch_valid=0, pc holds target. stall is ignored.
  - Counter decrements each cycle. When counter==0: state<=RUN, flush<=0, fetch_valid<=1, pc unchanged. The first valid fetch is at the target.
  - With FLUSH_CYCLES=1, flush is high for exactly one cycle.
- Latency: redirect accepted at edge N. flush is high in cycles N+1..N+FLUSH_CYCLES. fetch_valid=1 with pc=target from cycle N+FLUSH_CYCLES+1.
- Adjacent redirects: a redirect arriving in the first RUN cycle after FLUSH is accepted normally. Flush windows never overlap.
- Target alignment: see Optional Feature.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined, accepted redirect with redir_target[1:0]!=0:
  - pc<=TRAP_PC, misalign_err pulses 1 for the cycle after acceptance.
  - Flush sequence and redir_count increment are unchanged.
- Not defined:
  - redir_target[1:0] is forced to 2'b00 on load.
  - misalign_err is tied to 0 and TRAP_PC is unused.

Test Plan:
- Reset then 4 free cycles, stall=0, RESET_PC=0: pc shows 0,0,4,8,12. fetch_valid goes 0->1 on the first post-reset edge.
- pc=248, no stall, 3 cycles: pc shows 252, 0, 4 (wrap). No flush.
- Redirect at pc=16 with target=100, FLUSH_CYCLES=2:
  - flush=1 for 2 cycles, redir_ready=0 and fetch_valid=0 during them.
  - Then pc=100 with fetch_valid=1, pc=104 next cycle. redir_count=1.
- stall=1 and redir_valid=1 with target=40 on the same edge: redirect accepted and pc=40. A stall alone for 3 cycles holds pc constant.
- rst_n=0 during the second flush cycle: next cycle pc=RESET_PC, flush=0, redir_count=0, redir_ready=1.
- Redirect with target=0x65:
  - With MISALIGN_TRAP_EN: pc=252, misalign_err one-cycle pulse.
  - Without it: pc=0x64, misalign_err=0.
